// File: rtl/wb_write_queue_if.sv
// Bus bundle for wb_write_queue: pipeline/slow-unit inputs, register-file write port, scoreboard.
// Forwarding data signals exist only when WBQ_FORWARD_EN is defined.
interface wb_write_queue_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             pipe_we;
    logic [4:0]       pipe_rd;
    logic [WIDTH-1:0] pipe_data;
    logic             slow_valid;
    logic [4:0]       slow_rd;
    logic [WIDTH-1:0] slow_data;
    logic             slow_ready;
    logic             flush;
    logic [4:0]       rd_addr_0;
    logic [4:0]       rd_addr_1;
    logic             pend_hit_0;
    logic             pend_hit_1;
    logic             rf_write_enable;
    logic [4:0]       rf_dest;
    logic [WIDTH-1:0] rf_data;
    logic [CNT_W-1:0] count;
`ifdef WBQ_FORWARD_EN
    logic [WIDTH-1:0] fwd_data_0;
    logic [WIDTH-1:0] fwd_data_1;
`endif

    modport master (
        output pipe_we, pipe_rd, pipe_data, slow_valid, slow_rd, slow_data,
               flush, rd_addr_0, rd_addr_1,
        input  slow_ready, pend_hit_0, pend_hit_1, rf_write_enable, rf_dest,
               rf_data, count
`ifdef WBQ_FORWARD_EN
        , input fwd_data_0, fwd_data_1
`endif
    );

    modport slave (
        input  pipe_we, pipe_rd, pipe_data, slow_valid, slow_rd, slow_data,
               flush, rd_addr_0, rd_addr_1,
        output slow_ready, pend_hit_0, pend_hit_1, rf_write_enable, rf_dest,
               rf_data, count
`ifdef WBQ_FORWARD_EN
        , output fwd_data_0, fwd_data_1
`endif
    );
endinterface

// File: rtl/wb_write_queue.sv
// Register-file write-port arbiter with a pending-write queue for multi-cycle results.
// Define WBQ_FORWARD_EN to add youngest-live-entry forwarding data on each read port.
module wb_write_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    wb_write_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DEPTH-1:0] live_reg;
    logic [4:0]       rd_reg   [DEPTH];
    logic [WIDTH-1:0] data_reg [DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;

    logic not_empty;
    logic pop;
    logic push;
    logic enq_live;
    logic [DEPTH-1:0] hit0_vec;
    logic [DEPTH-1:0] hit1_vec;

    assign not_empty = (count_reg != '0);
    assign bus.slow_ready = (count_reg < CNT_FULL);
    // A killed head drains even under a pipe write because it needs no port cycle.
    assign pop      = not_empty && (!bus.pipe_we || !live_reg[head_reg]);
    assign push     = bus.slow_valid && bus.slow_ready;
    assign enq_live = !(bus.pipe_we && (bus.slow_rd == bus.pipe_rd));

    assign bus.rf_dest  = bus.pipe_we ? bus.pipe_rd   : rd_reg[head_reg];
    assign bus.rf_data  = bus.pipe_we ? bus.pipe_data : data_reg[head_reg];
    assign bus.rf_write_enable = reset && (bus.pipe_we || (not_empty && live_reg[head_reg]));
    assign bus.count    = count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (bus.flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (pop)  head_reg <= head_reg + PTR_ONE;
            if (push) tail_reg <= tail_reg + PTR_ONE;
            if (push && !pop)      count_reg <= count_reg + CNT_ONE;
            else if (pop && !push) count_reg <= count_reg - CNT_ONE;
        end
    end

    // Pipe writes are younger than anything queued, so matching queued entries die.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_reg[i]   <= '0;
                data_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.flush) begin
                    live_reg[i] <= 1'b0;
                end else if (push && (tail_reg == PTR_W'(i))) begin
                    live_reg[i] <= enq_live;
                    rd_reg[i]   <= bus.slow_rd;
                    data_reg[i] <= bus.slow_data;
                end else if ((pop && (head_reg == PTR_W'(i))) ||
                             (bus.pipe_we && (rd_reg[i] == bus.pipe_rd))) begin
                    live_reg[i] <= 1'b0;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit0_vec[gi] = live_reg[gi] && (rd_reg[gi] == bus.rd_addr_0);
            assign hit1_vec[gi] = live_reg[gi] && (rd_reg[gi] == bus.rd_addr_1);
        end
    endgenerate

    assign bus.pend_hit_0 = reset && (|hit0_vec);
    assign bus.pend_hit_1 = reset && (|hit1_vec);

`ifdef WBQ_FORWARD_EN
    logic [WIDTH-1:0] fwd0_next;
    logic [WIDTH-1:0] fwd1_next;
    logic [PTR_W-1:0] fwd_idx;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        fwd0_next = '0;
        fwd1_next = '0;
        fwd_idx   = head_reg;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_reg + PTR_W'(k);
            if (hit0_vec[fwd_idx]) fwd0_next = data_reg[fwd_idx];
            if (hit1_vec[fwd_idx]) fwd1_next = data_reg[fwd_idx];
        end
    end

    assign bus.fwd_data_0 = fwd0_next;
    assign bus.fwd_data_1 = fwd1_next;
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: queue-based reference model checked every cycle
// plus literal expectations for the reset, overflow, drain, kill, flush and forwarding cases.
module tb_wb_write_queue;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wb_write_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    wb_write_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        bit               live;
        logic [4:0]       rd;
        logic [WIDTH-1:0] data;
    } ent_t;

    typedef struct {
        logic [4:0]       rd;
        logic [WIDTH-1:0] data;
    } wr_t;

    ent_t mq[$];
    wr_t  wlog[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue in program order, updated per clock edge.
    always @(negedge reset) mq.delete();

    always @(posedge clk) begin : model_update
        bit   pop_ok;
        bit   acc;
        ent_t e;
        if (reset) begin
            if (bus.flush) begin
                mq.delete();
            end else begin
                pop_ok = (mq.size() > 0) && (!bus.pipe_we || !mq[0].live);
                acc    = bus.slow_valid && (mq.size() < DEPTH);
                if (bus.pipe_we)
                    foreach (mq[i]) if (mq[i].rd == bus.pipe_rd) mq[i].live = 1'b0;
                if (pop_ok) void'(mq.pop_front());
                if (acc) begin
                    e.live = !(bus.pipe_we && (bus.slow_rd == bus.pipe_rd));
                    e.rd   = bus.slow_rd;
                    e.data = bus.slow_data;
                    mq.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic             e_we;
        logic [4:0]       e_dest;
        logic [WIDTH-1:0] e_data;
        logic             e_h0;
        logic             e_h1;
        logic [WIDTH-1:0] e_f0;
        logic [WIDTH-1:0] e_f1;
        e_we = 1'b0; e_dest = '0; e_data = '0;
        e_h0 = 1'b0; e_h1 = 1'b0; e_f0 = '0; e_f1 = '0;
        if (reset) begin
            if (bus.pipe_we) begin
                e_we = 1'b1; e_dest = bus.pipe_rd; e_data = bus.pipe_data;
            end else if (mq.size() > 0) begin
                e_we = mq[0].live; e_dest = mq[0].rd; e_data = mq[0].data;
            end
            foreach (mq[i]) begin
                if (mq[i].live && mq[i].rd == bus.rd_addr_0) begin e_h0 = 1'b1; e_f0 = mq[i].data; end
                if (mq[i].live && mq[i].rd == bus.rd_addr_1) begin e_h1 = 1'b1; e_f1 = mq[i].data; end
            end
        end
        chk("rf_write_enable", 64'(bus.rf_write_enable), 64'(e_we));
        if (e_we) begin
            chk("rf_dest", 64'(bus.rf_dest), 64'(e_dest));
            chk("rf_data", 64'(bus.rf_data), 64'(e_data));
        end
        chk("count", 64'(bus.count), 64'(mq.size()));
        chk("slow_ready", 64'(bus.slow_ready), 64'(mq.size() < DEPTH));
        chk("pend_hit_0", 64'(bus.pend_hit_0), 64'(e_h0));
        chk("pend_hit_1", 64'(bus.pend_hit_1), 64'(e_h1));
`ifdef WBQ_FORWARD_EN
        chk("fwd_data_0", 64'(bus.fwd_data_0), 64'(e_f0));
        chk("fwd_data_1", 64'(bus.fwd_data_1), 64'(e_f1));
`else
        if (e_f0 != e_f1) e_f0 = e_f1;
`endif
        if (bus.rf_write_enable) wlog.push_back('{rd: bus.rf_dest, data: bus.rf_data});
    end

    task automatic idle_inputs();
        bus.pipe_we = 1'b0; bus.pipe_rd = '0; bus.pipe_data = '0;
        bus.slow_valid = 1'b0; bus.slow_rd = '0; bus.slow_data = '0;
        bus.flush = 1'b0; bus.rd_addr_0 = '0; bus.rd_addr_1 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        repeat (3) tick();
        chk("reset_count", 64'(bus.count), 64'(0));
        chk("reset_ready", 64'(bus.slow_ready), 64'(1));
        reset = 1'b1;
        tick();

        // Pipe write passes straight through.
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_data = 32'h11;
        #1;
        chk("pipe_we_out", 64'(bus.rf_write_enable), 64'(1));
        chk("pipe_dest", 64'(bus.rf_dest), 64'(3));
        chk("pipe_data", 64'(bus.rf_data), 64'(32'h11));
        chk("pipe_count", 64'(bus.count), 64'(0));
        tick();

        // Fill under a held pipe write; the fifth result must be refused.
        bus.pipe_rd = 5'd20; bus.pipe_data = 32'h99;
        for (int i = 1; i <= 5; i++) begin
            bus.slow_valid = 1'b1; bus.slow_rd = 5'(i); bus.slow_data = 32'hA0 + 32'(i);
            tick();
        end
        chk("full_count", 64'(bus.count), 64'(4));
        chk("full_ready", 64'(bus.slow_ready), 64'(0));
        bus.pipe_we = 1'b0; bus.slow_valid = 1'b0;
        wlog.delete();
        repeat (6) tick();
        chk("drain_writes", 64'(wlog.size()), 64'(4));
        for (int k = 0; k < 4; k++) begin
            if (wlog.size() > k) begin
                chk("drain_rd", 64'(wlog[k].rd), 64'(k + 1));
                chk("drain_data", 64'(wlog[k].data), 64'(32'hA1 + 32'(k)));
            end
        end
        chk("drain_idle_we", 64'(bus.rf_write_enable), 64'(0));

        // Reset mid-operation with three entries queued.
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd31; bus.pipe_data = 32'h55;
        for (int i = 1; i <= 3; i++) begin
            bus.slow_valid = 1'b1; bus.slow_rd = 5'(i); bus.slow_data = 32'hD0 + 32'(i);
            tick();
        end
        bus.slow_valid = 1'b0;
        chk("pre_reset_count", 64'(bus.count), 64'(3));
        #1 reset = 1'b0;
        #1;
        chk("rst_count", 64'(bus.count), 64'(0));
        chk("rst_we", 64'(bus.rf_write_enable), 64'(0));
        chk("rst_ready", 64'(bus.slow_ready), 64'(1));
        tick();
        reset = 1'b1;
        bus.pipe_we = 1'b0;
        wlog.delete();
        repeat (3) tick();
        chk("post_reset_writes", 64'(wlog.size()), 64'(0));

        // WAW kill: queued write to r5 is superseded by a pipe write.
        wlog.delete();
        bus.rd_addr_0 = 5'd5;
        bus.slow_valid = 1'b1; bus.slow_rd = 5'd5; bus.slow_data = 32'hB0;
        tick();
        bus.slow_valid = 1'b0;
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd5; bus.pipe_data = 32'hC0;
        #1;
        chk("kill_hit_before", 64'(bus.pend_hit_0), 64'(1));
        tick();
        bus.pipe_we = 1'b0;
        #1;
        chk("kill_hit_after", 64'(bus.pend_hit_0), 64'(0));
        chk("kill_pop_we", 64'(bus.rf_write_enable), 64'(0));
        chk("kill_count", 64'(bus.count), 64'(1));
        tick();
        chk("kill_drained", 64'(bus.count), 64'(0));
        repeat (2) tick();
        chk("r5_writes", 64'(wlog.size()), 64'(1));
        if (wlog.size() > 0) begin
            chk("r5_dest", 64'(wlog[0].rd), 64'(5));
            chk("r5_data", 64'(wlog[0].data), 64'(32'hC0));
        end

        // Flush beats a same-cycle enqueue.
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd31; bus.pipe_data = 32'h77;
        for (int i = 8; i <= 9; i++) begin
            bus.slow_valid = 1'b1; bus.slow_rd = 5'(i); bus.slow_data = 32'hE0 + 32'(i);
            tick();
        end
        bus.rd_addr_0 = 5'd8; bus.rd_addr_1 = 5'd9;
        #1;
        chk("flush_pre_count", 64'(bus.count), 64'(2));
        chk("flush_pre_hit1", 64'(bus.pend_hit_1), 64'(1));
        bus.slow_rd = 5'd10; bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0; bus.slow_valid = 1'b0; bus.pipe_we = 1'b0;
        #1;
        chk("flush_count", 64'(bus.count), 64'(0));
        chk("flush_hit0", 64'(bus.pend_hit_0), 64'(0));
        chk("flush_hit1", 64'(bus.pend_hit_1), 64'(0));
        wlog.delete();
        repeat (4) tick();
        chk("flush_writes", 64'(wlog.size()), 64'(0));

        // Two queued writes to r7: scoreboard hit, forwarding picks the younger.
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd31;
        bus.slow_valid = 1'b1; bus.slow_rd = 5'd7; bus.slow_data = 32'h10;
        tick();
        bus.slow_data = 32'h20;
        tick();
        bus.slow_valid = 1'b0; bus.rd_addr_1 = 5'd7;
        #1;
        chk("r7_hit1", 64'(bus.pend_hit_1), 64'(1));
`ifdef WBQ_FORWARD_EN
        chk("r7_fwd1", 64'(bus.fwd_data_1), 64'(32'h20));
`endif
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0; bus.pipe_we = 1'b0;

        // Mixed traffic: overlapping destinations, simultaneous push/pop, kills.
        for (int i = 0; i < 16; i++) begin
            bus.pipe_we    = (i % 3 == 0);
            bus.pipe_rd    = 5'((i % 4) + 1);
            bus.pipe_data  = 32'h300 + 32'(i);
            bus.slow_valid = (i % 5 != 4);
            bus.slow_rd    = 5'((i % 4) + 2);
            bus.slow_data  = 32'h400 + 32'(i);
            bus.rd_addr_0  = 5'(i % 6);
            bus.rd_addr_1  = 5'((i + 2) % 6);
            tick();
        end
        idle_inputs();
        repeat (6) tick();
        chk("final_count", 64'(bus.count), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
